// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the inst/data memory port arbiter.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic OWN_INST = 1'b0;
   localparam logic OWN_DATA = 1'b1;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   localparam int MEM_REQ_W = 1 + 2 + 4 + 32 + 32;

   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

   // A fetch is always a full-word read with no strobes or write data.
   function automatic mem_req_t pack_inst_req(input logic [31:0] addr);
      mem_req_t r;
      r.wr    = 1'b0;
      r.size  = SIZE_W;
      r.wstrb = 4'b0000;
      r.addr  = addr;
      r.wdata = 32'h0000_0000;
      return r;
   endfunction

   function automatic mem_req_t pack_data_req(input logic        wr,
                                              input logic [1:0]  size,
                                              input logic [3:0]  wstrb,
                                              input logic [31:0] addr,
                                              input logic [31:0] wdata);
      mem_req_t r;
      r.wr    = wr;
      r.size  = size;
      r.wstrb = wstrb;
      r.addr  = addr;
      r.wdata = wdata;
      return r;
   endfunction

   // Increment that sticks at the limit instead of wrapping.
   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] lim);
      return (v >= lim) ? lim : (v + 4'd1);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Priority pick between fetch and load/store, with a starvation counter
// that forces a fetch grant after too many data grants in a row.
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inst_req,
   input  logic data_req,
   input  logic grant_en,
   output logic grant_inst,
   output logic grant_data
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt_r;
   logic       starve_hit_s;

   assign starve_hit_s = (starve_cnt_r == LIMIT);

   // Data wins by default; fetch wins when alone or when it has waited long enough.
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (grant_en) begin
         if (inst_req && (!data_req || starve_hit_s)) begin
            grant_inst = 1'b1;
         end else if (data_req) begin
            grant_data = 1'b1;
         end else begin
            grant_inst = 1'b0;
         end
      end else begin
         grant_data = 1'b0;
      end
   end

   // Count data grants that overtook a waiting fetch; any other grant clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt_r <= 4'd0;
      end else if (grant_data) begin
         starve_cnt_r <= inst_req ? sat_inc(starve_cnt_r, LIMIT) : 4'd0;
      end else if (grant_inst) begin
         starve_cnt_r <= 4'd0;
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one sram-like memory port between fetch and load/store. One
// transaction in flight: grant in IDLE, replay request in ADDR until the
// bridge accepts, then route the response to the owner in DATA.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   state_t   state_r;
   state_t   state_nx_s;
   logic     owner_r;
   mem_req_t latch_r;
   logic     grant_en_s;
   logic     grant_inst_s;
   logic     grant_data_s;

   // Grants only happen in IDLE, and never while reset holds every output low.
   assign grant_en_s = (state_r == ST_IDLE) && !rst;

   mem_arb_pick #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_pick (
      .clk        (clk),
      .rst        (rst),
      .inst_req   (inst_req),
      .data_req   (data_req),
      .grant_en   (grant_en_s),
      .grant_inst (grant_inst_s),
      .grant_data (grant_data_s)
   );

   // Next-state: a data_ok seen in ADDR is ignored because ADDR only looks at addr_ok.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (grant_inst_s || grant_data_s) begin
               state_nx_s = ST_ADDR;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (mem_addr_ok) begin
               state_nx_s = ST_DATA;
            end else begin
               state_nx_s = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (mem_data_ok) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DATA;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Capture owner and the winning request so it can be replayed unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_r <= OWN_INST;
         latch_r <= mem_req_t'({MEM_REQ_W{1'b0}});
      end else if (grant_data_s) begin
         owner_r <= OWN_DATA;
         latch_r <= pack_data_req(data_wr, data_size, data_wstrb, data_addr, data_wdata);
      end else if (grant_inst_s) begin
         owner_r <= OWN_INST;
         latch_r <= pack_inst_req(inst_addr);
      end else begin
         owner_r <= owner_r;
         latch_r <= latch_r;
      end
   end

   // Output routing: addr_ok in IDLE, memory request in ADDR, response to owner in DATA.
   always_comb begin
      inst_addr_ok = 1'b0;
      data_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'h0000_0000;
      data_data_ok = 1'b0;
      data_rdata   = 32'h0000_0000;
      mem_req      = 1'b0;
      mem_wr       = 1'b0;
      mem_size     = 2'b00;
      mem_wstrb    = 4'b0000;
      mem_addr     = 32'h0000_0000;
      mem_wdata    = 32'h0000_0000;
      case (state_r)
         ST_IDLE: begin
            inst_addr_ok = grant_inst_s;
            data_addr_ok = grant_data_s;
         end
         ST_ADDR: begin
            mem_req   = 1'b1;
            mem_wr    = latch_r.wr;
            mem_size  = latch_r.size;
            mem_wstrb = latch_r.wstrb;
            mem_addr  = latch_r.addr;
            mem_wdata = latch_r.wdata;
         end
         ST_DATA: begin
            if (owner_r == OWN_DATA) begin
               data_data_ok = mem_data_ok;
               data_rdata   = mem_rdata;
            end else begin
               inst_data_ok = mem_data_ok;
               inst_rdata   = mem_rdata;
            end
         end
         default: begin
            mem_req = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a transaction-level reference
// model checked every cycle and a bench-side memory bridge with tunable latency.
module tb_mem_port_arbiter;

   localparam int          LIMIT  = 4;
   localparam logic [31:0] RD_KEY = 32'hA5A5_0F0F;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req;
   logic        mem_wr;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_addr_ok;
   logic        mem_data_ok;
   logic [31:0] mem_rdata;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // bridge configuration and state
   int          addr_lat    = 0;
   int          data_lat    = 1;
   bit          use_fixed   = 1'b0;
   bit          spurious    = 1'b0;
   logic [31:0] fixed_rdata = 32'h0;
   int          b_wait;
   int          b_dcnt;
   bit          b_acc;
   bit          b_dph;
   logic [31:0] b_rdata;

   // reference model: the one outstanding transaction, as a record
   bit          m_busy    = 1'b0;
   bit          m_acc     = 1'b0;
   bit          m_is_data = 1'b0;
   bit          m_wr      = 1'b0;
   logic [1:0]  m_size    = 2'd0;
   logic [3:0]  m_wstrb   = 4'd0;
   logic [31:0] m_addr    = 32'h0;
   logic [31:0] m_wdata   = 32'h0;
   int          m_streak  = 0;

   mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not reach summary (cycle %0d)", cyc);
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   // Memory bridge: addr_ok after addr_lat waiting cycles, data_ok data_lat cycles after accept.
   initial begin
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = 32'h0;
      b_wait = 0; b_dcnt = 0; b_acc = 1'b0; b_dph = 1'b0; b_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         mem_addr_ok = 1'b0;
         mem_data_ok = 1'b0;
         if (rst) begin
            b_wait = 0; b_dcnt = 0; b_acc = 1'b0; b_dph = 1'b0;
            mem_rdata = 32'h0;
         end else begin
            mem_rdata = ~b_rdata;
            if (b_acc) begin
               b_acc = 1'b0; b_dph = 1'b1; b_dcnt = 0;
            end
            if (b_dph) begin
               b_dcnt++;
               if (b_dcnt >= data_lat) begin
                  mem_data_ok = 1'b1;
                  mem_rdata   = b_rdata;
                  b_dph       = 1'b0;
               end
            end else if (mem_req) begin
               if (b_wait >= addr_lat) begin
                  mem_addr_ok = 1'b1;
                  b_acc       = 1'b1;
                  b_wait      = 0;
                  b_rdata     = use_fixed ? fixed_rdata : (mem_addr ^ RD_KEY);
                  mem_data_ok = spurious;
               end else begin
                  b_wait++;
               end
            end
         end
      end
   end

   // Compare every DUT output against the model, then advance the model one cycle.
   task automatic model_check();
      bit          e_iaok, e_daok, e_mreq, e_idok, e_ddok, owned;
      logic [31:0] e_ird, e_drd;
      cyc++;
      if (rst) begin
         chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
         chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
         chk("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
         chk("rst_data_data_ok", 32'(data_data_ok), 32'd0);
         chk("rst_inst_rdata", inst_rdata, 32'd0);
         chk("rst_data_rdata", data_rdata, 32'd0);
         chk("rst_mem_ctl", 32'({mem_req, mem_wr, mem_size, mem_wstrb}), 32'd0);
         chk("rst_mem_addr", mem_addr, 32'd0);
         chk("rst_mem_wdata", mem_wdata, 32'd0);
         m_busy = 1'b0; m_acc = 1'b0; m_streak = 0;
      end else begin
         e_iaok = !m_busy && inst_req && (!data_req || (m_streak == LIMIT));
         e_daok = !m_busy && data_req && !e_iaok;
         e_mreq = m_busy && !m_acc;
         owned  = m_busy && m_acc;
         e_idok = owned && !m_is_data && mem_data_ok;
         e_ddok = owned && m_is_data && mem_data_ok;
         e_ird  = (owned && !m_is_data) ? mem_rdata : 32'h0;
         e_drd  = (owned && m_is_data) ? mem_rdata : 32'h0;
         chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
         chk("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
         chk("mem_req", 32'(mem_req), 32'(e_mreq));
         chk("inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
         chk("data_data_ok", 32'(data_data_ok), 32'(e_ddok));
         chk("inst_rdata", inst_rdata, e_ird);
         chk("data_rdata", data_rdata, e_drd);
         if (e_mreq) begin
            chk("mem_wr", 32'(mem_wr), 32'(m_wr));
            chk("mem_size", 32'(mem_size), 32'(m_size));
            chk("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wdata);
         end
         if (e_iaok || e_daok) begin
            m_busy = 1'b1; m_acc = 1'b0; m_is_data = e_daok;
            if (e_daok) begin
               m_wr = data_wr; m_size = data_size; m_wstrb = data_wstrb;
               m_addr = data_addr; m_wdata = data_wdata;
               m_streak = inst_req ? ((m_streak < LIMIT) ? m_streak + 1 : LIMIT) : 0;
            end else begin
               m_wr = 1'b0; m_size = 2'd2; m_wstrb = 4'd0;
               m_addr = inst_addr; m_wdata = 32'h0;
               m_streak = 0;
            end
         end else if (e_mreq && mem_addr_ok) begin
            m_acc = 1'b1;
         end else if (owned && mem_data_ok) begin
            m_busy = 1'b0;
         end
      end
   endtask

   task automatic to_neg();
      @(negedge clk);
      model_check();
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      to_neg();
      to_pos();
   endtask

   // Wait (bounded) for the outstanding transaction to return its data_ok.
   task automatic drain(input string nm);
      bit seen;
      int n;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
         to_neg();
         seen = inst_data_ok | data_data_ok;
         to_pos();
         n++;
      end
      chk(nm, 32'(seen), 32'd1);
   endtask

   task automatic set_load(input logic [31:0] a);
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'd0;
      data_addr = a; data_wdata = 32'h0;
   endtask

   initial begin
      logic [31:0] addr_q[$];
      logic [31:0] exp_rd;
      byte         got[10];
      string       order_exp;
      int          ngrant;
      int          nret;
      int          last;
      int          n;
      bit          granted;

      // reset with both requests up: no grant may leak out
      rst = 1'b1; inst_req = 1'b1; inst_addr = 32'h0;
      set_load(32'h0);
      to_pos();
      to_neg();
      chk("reset_addr_ok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
      chk("reset_mem_req", 32'(mem_req), 32'd0);
      to_pos();
      inst_req = 1'b0; data_req = 1'b0; rst = 1'b0;
      step();
      step();

      // single load
      addr_lat = 1; data_lat = 2; use_fixed = 1'b1; fixed_rdata = 32'hDEADBEEF;
      set_load(32'h1C00_0010);
      to_neg();
      chk("load_addr_ok_c0", 32'(data_addr_ok), 32'd1);
      to_pos();
      data_req = 1'b0; data_addr = 32'hFFFF_FFFF;
      for (int k = 1; k <= 4; k++) begin
         to_neg();
         chk("load_mem_req", 32'(mem_req), (k == 1 || k == 2) ? 32'd1 : 32'd0);
         chk("load_data_ok", 32'(data_data_ok), (k == 4) ? 32'd1 : 32'd0);
         chk("load_inst_data_ok", 32'(inst_data_ok), 32'd0);
         if (k <= 2) chk("load_mem_addr", mem_addr, 32'h1C00_0010);
         if (k == 4) chk("load_rdata", data_rdata, 32'hDEADBEEF);
         to_pos();
      end
      use_fixed = 1'b0;
      step();

      // byte store held through a 3-cycle addr stall
      addr_lat = 3; data_lat = 1;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0; data_wstrb = 4'b0100;
      data_addr = 32'h1C00_0022; data_wdata = 32'h00AB_0000;
      to_neg();
      chk("store_addr_ok", 32'(data_addr_ok), 32'd1);
      to_pos();
      data_req = 1'b0; data_wstrb = 4'b1111; data_wdata = 32'h1234_5678;
      for (int k = 1; k <= 5; k++) begin
         to_neg();
         if (k <= 4) begin
            chk("store_mem_req", 32'(mem_req), 32'd1);
            chk("store_mem_wr", 32'(mem_wr), 32'd1);
            chk("store_mem_size", 32'(mem_size), 32'd0);
            chk("store_mem_wstrb", 32'(mem_wstrb), 32'h4);
            chk("store_mem_wdata", mem_wdata, 32'h00AB_0000);
         end
         chk("store_data_ok", 32'(data_data_ok), (k == 5) ? 32'd1 : 32'd0);
         to_pos();
      end
      data_wr = 1'b0;
      step();

      // long addr stall with a fetch waiting behind a load
      addr_lat = 10; data_lat = 1;
      set_load(32'h1C00_0100);
      to_neg();
      chk("stall_data_addr_ok", 32'(data_addr_ok), 32'd1);
      to_pos();
      data_req = 1'b0; data_addr = 32'h0BAD_0BAD;
      inst_req = 1'b1; inst_addr = 32'h0000_2000;
      for (int k = 1; k <= 13; k++) begin
         to_neg();
         chk("stall_inst_addr_ok", 32'(inst_addr_ok), (k == 13) ? 32'd1 : 32'd0);
         if (k <= 11) begin
            chk("stall_mem_req", 32'(mem_req), 32'd1);
            chk("stall_mem_addr", mem_addr, 32'h1C00_0100);
            chk("stall_mem_size", 32'(mem_size), 32'd2);
         end
         if (k == 12) chk("stall_data_ok", 32'(data_data_ok), 32'd1);
         to_pos();
      end
      inst_req = 1'b0; addr_lat = 0;
      drain("stall_fetch_done");
      step();

      // back-to-back fetch, 1-cycle bridge
      addr_lat = 0; data_lat = 1;
      inst_req = 1'b1; inst_addr = 32'h0000_1000;
      ngrant = 0; nret = 0; last = 0;
      for (int k = 0; k < 18; k++) begin
         to_neg();
         granted = inst_addr_ok;
         if (granted) begin
            if (ngrant > 0) chk("b2b_spacing", 32'(cyc - last), 32'd3);
            last = cyc;
            addr_q.push_back(inst_addr);
            ngrant++;
         end
         if (inst_data_ok) begin
            nret++;
            if (addr_q.size() > 0) begin
               exp_rd = addr_q.pop_front() ^ RD_KEY;
               chk("b2b_rdata", inst_rdata, exp_rd);
            end
         end
         to_pos();
         if (granted) inst_addr = inst_addr + 32'd4;
      end
      inst_req = 1'b0;
      chk("b2b_grants", 32'(ngrant), 32'd6);
      chk("b2b_returns", 32'(nret), 32'd6);
      step();

      // both requesting continuously: starvation counter pattern
      inst_req = 1'b1; inst_addr = 32'h0000_3000;
      set_load(32'h1C00_0200);
      ngrant = 0; n = 0;
      while (ngrant < 10 && n < 60) begin
         to_neg();
         if (inst_addr_ok && data_addr_ok) begin
            got[ngrant] = "X"; ngrant++;
         end else if (inst_addr_ok) begin
            got[ngrant] = "I"; ngrant++;
         end else if (data_addr_ok) begin
            got[ngrant] = "D"; ngrant++;
         end
         to_pos();
         n++;
      end
      inst_req = 1'b0; data_req = 1'b0;
      chk("order_count", 32'(ngrant), 32'd10);
      order_exp = "DDDDIDDDDI";
      for (int i = 0; i < ngrant; i++) begin
         chk("order_grant", 32'(got[i]), 32'(order_exp[i]));
      end
      drain("order_done");
      step();

      // reset while in DATA, then a fetch is granted immediately
      addr_lat = 0; data_lat = 8;
      set_load(32'h1C00_0300);
      to_neg();
      chk("mid_addr_ok", 32'(data_addr_ok), 32'd1);
      to_pos();
      data_req = 1'b0;
      step();
      step();
      rst = 1'b1; inst_req = 1'b1; inst_addr = 32'h0000_4000;
      to_neg();
      chk("mid_rst_outputs", 32'({inst_addr_ok, data_addr_ok, mem_req, data_data_ok}), 32'd0);
      to_pos();
      step();
      rst = 1'b0; data_lat = 1;
      to_neg();
      chk("post_rst_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      to_pos();
      inst_req = 1'b0;
      drain("post_rst_done");
      step();

      // data_ok arriving together with addr_ok must be ignored
      spurious = 1'b1; addr_lat = 0; data_lat = 2;
      set_load(32'h1C00_0400);
      to_neg();
      chk("spur_addr_ok", 32'(data_addr_ok), 32'd1);
      to_pos();
      data_req = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         to_neg();
         chk("spur_data_ok", 32'(data_data_ok), (k == 3) ? 32'd1 : 32'd0);
         to_pos();
      end
      spurious = 1'b0;
      step();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one sram-like memory port between the fetch-side requester (inst) and the execute-side load/store requester (data).
- Carries one transaction at a time. Captures the winning request, replays it to memory until accepted, then returns the response to its owner.
- Data side has priority. A bounded starvation counter guarantees forward progress for fetch.
- Sits between the Fetch/Execute stages and the memory bridge.

Parameters:
- STARVE_LIMIT, 4: maximum consecutive data grants taken while inst_req is pending before inst is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  32  fetch address; word read, size 2'b10
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  32  fetch read data
- data_req  in  1  load/store request; held until data_addr_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_wstrb  in  4  byte strobes for stores
- data_addr  in  32  load/store address
- data_wdata  in  32  store data
- data_addr_ok  out  1  load/store request accepted this cycle
- data_data_ok  out  1  load data valid, or store complete, this cycle
- data_rdata  out  32  load data
- mem_req  out  1  memory request
- mem_wr  out  1  memory write
- mem_size  out  2  memory access size
- mem_wstrb  out  4  memory byte strobes
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response valid
- mem_rdata  in  32  memory read data

Behaviour:
- States: IDLE, ADDR, DATA. State encoding 2 bits.
- Registers: owner (0 = inst, 1 = data), a request latch {wr, size, wstrb, addr, wdata}, and starve_cnt (4 bits).
- Reset (async, rst = 1) forces:
  - state = IDLE, owner = 0, latch = 0, starve_cnt = 0
  - all outputs 0: addr_ok, data_ok, mem_req, and all mem_* buses
  - any in-flight transaction is dropped; the memory bridge is reset by the same rst.
- IDLE, grant selection:
  - only data_req: data wins.
  - only inst_req: inst wins.
  - both requesting: data wins unless starve_cnt == STARVE_LIMIT, in which case inst wins.
  - On grant, the winner's addr_ok = 1 combinationally in the same cycle.
  - On grant, the latch and owner load at the clock edge and state moves to ADDR.
  - An inst grant latches wr = 0, size = 2, wstrb = 0, wdata = 0.
- starve_cnt update, on grant only:
  - data grant with inst_req = 1: starve_cnt + 1, saturating at STARVE_LIMIT.
  - data grant with inst_req = 0: starve_cnt = 0.
  - inst grant: starve_cnt = 0.
- ADDR:
  - mem_req = 1 and mem_* driven from the latch, held stable until mem_addr_ok.
  - mem_addr_ok = 1: next state is DATA. mem_req is never asserted outside ADDR.
- DATA:
  - owner's data_ok = mem_data_ok. Owner's rdata = mem_rdata (combinational pass-through).
  - Non-owner data_ok = 0. rdata outputs are 0 when their side is not owner in DATA.
  - mem_data_ok = 1: next state is IDLE.
  - mem_data_ok asserted in the same cycle as mem_addr_ok in ADDR is ignored; the bridge contract requires data_ok no earlier than the cycle after addr_ok.
- addr_ok is asserted only in IDLE. Requests that arrive in ADDR or DATA wait.
- Minimum transaction is 3 cycles (grant, addr, data). Back-to-back requests get the next grant in the IDLE cycle right after data_ok.
- Requests are sampled only at grant. A requester dropping req before addr_ok is legal and is not granted.

Decomposition:
- Shared package/defines (Defines.vh):
  - state encodings ST_IDLE/ST_ADDR/ST_DATA
  - owner codes OWN_INST/OWN_DATA
  - size codes SIZE_B/SIZE_H/SIZE_W
  - request latch width MEM_REQ_Wid = 1+2+4+32+32
- Sub-module mem_arb_pick: combinational priority pick plus the starve_cnt register. Inputs inst_req, data_req, grant_en. Outputs grant_inst, grant_data.
- The top holds the FSM, latch and response routing.

Test Plan:
- Reset mid-transaction: assert rst while in DATA, then deassert -> all outputs 0, state IDLE; next inst_req is granted with inst_addr_ok in its first cycle.
- Single load: data_req with addr 0x1C000010, size 2; bridge gives addr_ok 1 cycle later and data_ok 2 cycles after that with rdata 0xDEADBEEF -> data_addr_ok at cycle 0, mem_req high cycles 1-2, data_data_ok with 0xDEADBEEF at cycle 4, inst_data_ok stays 0.
- Store strobes: data_wr = 1, size 0, wstrb 4'b0100, wdata 0x00AB0000 -> mem_wr = 1, mem_wstrb 4'b0100, mem_wdata 0x00AB0000 held unchanged while mem_addr_ok is low for 3 cycles.
- Simultaneous requests with STARVE_LIMIT = 4: inst_req and data_req held continuously -> grant order D, D, D, D, I, D, D, D, D, I.
- Mem stall: mem_addr_ok low for 10 cycles in ADDR with inst_req pending -> inst_addr_ok stays 0 and mem_* stay stable throughout.
- Back-to-back fetch: inst_req held, bridge 1-cycle latency -> inst_addr_ok every 3 cycles; each inst_data_ok returns the matching mem_rdata.
